// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty scheduler: default resolution,
// duty type and the channel-index width helper.
package pwm_pkg;

  localparam int DUTY_RES = 8;

  typedef logic [DUTY_RES-1:0] duty_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the valid vector,
// pointer advances past the winner on each accepted transfer.
module rr_arbiter
  import pwm_pkg::*;
#(
  parameter int REQ = 2,
  parameter int IW  = clog2_min1(REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [REQ-1:0] valid_i,
  input  logic           adv_i,
  output logic [REQ-1:0] grant_o,
  output logic [IW-1:0]  win_o
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    logic found;
    int   idx;
    grant_o = '0;
    win_o   = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % REQ;
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        win_o        = IW'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Pointer moves to winner+1 (mod REQ) only when a transfer happens.
  always_comb begin
    if (adv_i) begin
      if (win_o == IW'(REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_o + IW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Arbitrates duty updates from several requesters into per-channel shadows
// and commits them to the live duty bus only on a PWM period boundary.
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int RES = DUTY_RES,
  parameter int CHN = 4,
  parameter int REQ = 2,
  parameter int CW  = clog2_min1(CHN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               period_tick,
  input  logic [REQ-1:0]     req_valid,
  input  logic [REQ*CW-1:0]  req_chan,
  input  logic [REQ*RES-1:0] req_duty,
  output logic [REQ-1:0]     req_ready,
  output logic [RES*CHN-1:0] duty_out,
  output logic [CHN-1:0]     pending,
  output logic               commit_pulse,
  output logic               err
);

  localparam int IW = clog2_min1(REQ);

  logic [IW-1:0]  win_s;
  logic           accept_s;
  logic [CW-1:0]  sel_chan_s;
  logic [RES-1:0] sel_duty_s;
  logic           in_range_s;
  logic [CHN-1:0] wr_s;

  logic [RES-1:0] shadow_q [CHN];
  logic [RES-1:0] shadow_d [CHN];
  logic [RES-1:0] live_q   [CHN];
  logic [RES-1:0] live_d   [CHN];
  logic [CHN-1:0] pending_q;
  logic [CHN-1:0] pending_d;
  logic           commit_pulse_q;
  logic           commit_pulse_d;
  logic           err_q;
  logic           err_d;

  rr_arbiter #(.REQ(REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .adv_i   (accept_s),
    .grant_o (req_ready),
    .win_o   (win_s)
  );

  assign accept_s   = |(req_valid & req_ready);
  assign sel_chan_s = req_chan[win_s*CW +: CW];
  assign sel_duty_s = req_duty[win_s*RES +: RES];
  assign in_range_s = (int'(sel_chan_s) < CHN);

  // Commit reads the pre-edge shadow, so a same-edge write stays pending.
  for (genvar n = 0; n < CHN; n++) begin : g_chan
    assign wr_s[n]      = accept_s & in_range_s & (sel_chan_s == CW'(n));
    assign shadow_d[n]  = wr_s[n] ? sel_duty_s : shadow_q[n];
    assign live_d[n]    = (period_tick & pending_q[n]) ? shadow_q[n] : live_q[n];
    assign pending_d[n] = wr_s[n] | (pending_q[n] & ~period_tick);
    assign duty_out[n*RES +: RES] = live_q[n];
  end

  assign commit_pulse_d = period_tick & (|pending_q);
  assign err_d          = err_q | (accept_s & ~in_range_s);

  // Shadow, live, pending and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHN; n++) begin
        shadow_q[n] <= '0;
        live_q[n]   <= '0;
      end
      pending_q      <= '0;
      commit_pulse_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      for (int n = 0; n < CHN; n++) begin
        shadow_q[n] <= shadow_d[n];
        live_q[n]   <= live_d[n];
      end
      pending_q      <= pending_d;
      commit_pulse_q <= commit_pulse_d;
      err_q          <= err_d;
    end
  end

  assign pending      = pending_q;
  assign commit_pulse = commit_pulse_q;
  assign err          = err_q;

endmodule
